// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the
// instruction-fetch (I) and load/store (D) ports, with registered SRAM pins.
module mem_port_arbiter #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] rdata,
    output logic          stall,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic          mem_oen,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // When both ports contend, the one not served last wins.
    function automatic logic pick_port(input logic i_r, input logic d_r, input logic last);
        if (i_r && d_r) begin
            return ~last;
        end else if (d_r) begin
            return PORT_D;
        end else begin
            return PORT_I;
        end
    endfunction

    state_t        state_r, state_nxt_s;
    logic          gnt_r, gnt_nxt_s;
    logic          last_r, last_nxt_s;
    logic          is_rd_r, is_rd_nxt_s;
    logic          mem_cen_r, mem_cen_nxt_s;
    logic          mem_wen_r, mem_wen_nxt_s;
    logic          mem_oen_r, mem_oen_nxt_s;
    logic [AW-1:0] mem_a_r, mem_a_nxt_s;
    logic [DW-1:0] mem_d_r, mem_d_nxt_s;

    logic          load_s;
    logic          sel_port_s;
    logic          ld_is_rd_s;
    logic [AW-1:0] ld_addr_s;
    logic [DW-1:0] ld_wdata_s;

    // In RESP only the port that was not just acked may be granted.
    assign sel_port_s = (state_r == ST_RESP) ? ~gnt_r : pick_port(i_req, d_req, last_r);
    assign ld_is_rd_s = sel_port_s ? ~d_we : 1'b1;
    assign ld_addr_s  = sel_port_s ? d_addr : i_addr;
    assign ld_wdata_s = (sel_port_s && d_we) ? d_wdata : {DW{1'b0}};

    // Next-state and next-pin logic for the access sequencer.
    always_comb begin
        load_s        = 1'b0;
        state_nxt_s   = state_r;
        gnt_nxt_s     = gnt_r;
        last_nxt_s    = last_r;
        is_rd_nxt_s   = is_rd_r;
        mem_cen_nxt_s = mem_cen_r;
        mem_wen_nxt_s = mem_wen_r;
        mem_oen_nxt_s = mem_oen_r;
        mem_a_nxt_s   = mem_a_r;
        mem_d_nxt_s   = mem_d_r;
        case (state_r)
            ST_IDLE: begin
                load_s = i_req | d_req;
            end
            ST_ACCESS: begin
                load_s        = 1'b0;
                mem_cen_nxt_s = 1'b1;
                mem_wen_nxt_s = 1'b1;
                mem_oen_nxt_s = ~is_rd_r;
            end
            ST_RESP: begin
                mem_oen_nxt_s = 1'b1;
                load_s        = gnt_r ? i_req : d_req;
            end
            default: begin
                load_s        = 1'b0;
                mem_cen_nxt_s = 1'b1;
                mem_wen_nxt_s = 1'b1;
                mem_oen_nxt_s = 1'b1;
            end
        endcase
        if (load_s) begin
            state_nxt_s   = ST_ACCESS;
            gnt_nxt_s     = sel_port_s;
            last_nxt_s    = sel_port_s;
            is_rd_nxt_s   = ld_is_rd_s;
            mem_cen_nxt_s = 1'b0;
            mem_wen_nxt_s = ld_is_rd_s;
            mem_a_nxt_s   = ld_addr_s;
            mem_d_nxt_s   = ld_wdata_s;
        end else begin
            state_nxt_s = (state_r == ST_ACCESS) ? ST_RESP : ST_IDLE;
        end
    end

    // State and SRAM pin registers; last resets to D so I wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            gnt_r     <= PORT_I;
            last_r    <= PORT_D;
            is_rd_r   <= 1'b0;
            mem_cen_r <= 1'b1;
            mem_wen_r <= 1'b1;
            mem_oen_r <= 1'b1;
            mem_a_r   <= {AW{1'b0}};
            mem_d_r   <= {DW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            gnt_r     <= gnt_nxt_s;
            last_r    <= last_nxt_s;
            is_rd_r   <= is_rd_nxt_s;
            mem_cen_r <= mem_cen_nxt_s;
            mem_wen_r <= mem_wen_nxt_s;
            mem_oen_r <= mem_oen_nxt_s;
            mem_a_r   <= mem_a_nxt_s;
            mem_d_r   <= mem_d_nxt_s;
        end
    end

    assign mem_cen = mem_cen_r;
    assign mem_wen = mem_wen_r;
    assign mem_oen = mem_oen_r;
    assign mem_a   = mem_a_r;
    assign mem_d   = mem_d_r;

    assign i_ack = (state_r == ST_RESP) && (gnt_r == PORT_I);
    assign d_ack = (state_r == ST_RESP) && (gnt_r == PORT_D);
    assign rdata = ((state_r == ST_RESP) && is_rd_r) ? mem_q : {DW{1'b0}};
    assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous data SRAM between two requesters: the instruction-fetch port (I) and the load/store port (D) of the MIPS core. It arbitrates round-robin, sequences each access through a three-state FSM, drives the active-low SRAM controls from registers, and returns a one-cycle ack per transaction. It also produces a `stall` signal that freezes the core's PC and register-file write while any request is outstanding.

## Interface
- `AW`, default 7: SRAM word-address width.
- `DW`, default 32: data width.

Reset is `rst_n`, synchronous, active-low. The clock is `clk`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `i_req`  in  1  I-port request; held with `i_addr` until `i_ack`.
- `i_addr`  in  AW  I-port word address.
- `i_ack`  out  1  I-port access complete; read data is valid on `rdata` this cycle.
- `d_req`  in  1  D-port request; held with `d_we`, `d_addr`, `d_wdata` until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  AW  D-port word address.
- `d_wdata`  in  DW  D-port write data.
- `d_ack`  out  1  D-port access complete.
- `rdata`  out  DW  read data, shared by both ports; equals `mem_q` when a read is acked, 0 otherwise.
- `stall`  out  1  `(i_req & ~i_ack) | (d_req & ~d_ack)`, combinational.
- `mem_cen`  out  1  SRAM chip enable, active-low, registered.
- `mem_wen`  out  1  SRAM write enable, active-low, registered.
- `mem_oen`  out  1  SRAM output enable, active-low, registered.
- `mem_a`  out  AW  SRAM address, registered.
- `mem_d`  out  DW  SRAM write data, registered.
- `mem_q`  in  DW  SRAM read data; valid in the cycle after the cycle in which `mem_cen` = 0 with `mem_wen` = 1.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **Registers:** `state`, `gnt` (0 = I, 1 = D), `last` (last granted port), `is_rd`.
- **Arbitration (in IDLE):**
  - If only one port requests, grant that port.
  - If both request, grant the port that is not `last`.
  - On a grant, `last <= gnt`.
  - The I port is always a read. For the D port, `is_rd = ~d_we`.
- **IDLE:** if any request is present, go to ACCESS and load the pins from the granted port:
  - `mem_cen <= 0`
  - `mem_wen <= ~we`
  - `mem_a <= addr`
  - `mem_d <= d_wdata` for a D write, else 0.
- **ACCESS:** the SRAM samples at the end of this cycle. At the edge:
  - `mem_cen <= 1`, `mem_wen <= 1`.
  - `mem_oen <= ~is_rd`.
  - Go to RESP.
- **RESP:**
  - Assert `ack` of `gnt`, combinationally from state.
  - For a read, `rdata = mem_q`.
  - At the edge, `mem_oen <= 1`.
  - Arbitrate only the non-acked port. If it requests, grant it, load the pins and go to ACCESS; otherwise go to IDLE.
  - A `req` still high on the acked port in the cycle after its ack is a new request.
- **Address and data handling:**
  - Addresses and data pass through unmodified.
  - There is no byte masking.
  - Out-of-range addresses wrap naturally at AW bits.

## Timing
- **Reset values:**
  - `state` = IDLE, `last` = D (so I wins the first contention), `gnt` = 0.
  - `mem_cen` = `mem_wen` = `mem_oen` = 1.
  - `mem_a` = 0, `mem_d` = 0.
  - `i_ack` = `d_ack` = 0, `rdata` = 0.
- **Single access latency:** `req` seen in IDLE in cycle N gives pins active in N+1 and ack in N+2. Reads and writes are identical.
- **Contended throughput:** one access per 2 cycles, because RESP chains directly to ACCESS.
- **Port fairness:** neither port waits more than one other transaction.
- **Ack and stall behaviour:**
  - `ack` is high for exactly one cycle per transaction.
  - `i_ack` and `d_ack` are never high together.
  - `stall` is 0 in the ack cycle of the last pending request.
- **Requester rule:** the requester must not change `addr`/`we`/`wdata` or drop `req` before ack. If it drops `req` early, the transaction still completes and the ack is still issued.
- **Reset mid-transaction:** reset asserted in ACCESS or RESP forces all reset values at the next edge. No ack is produced and the SRAM pins are deasserted.
- **Pin relationships:**
  - `mem_oen` = 0 only in the RESP cycle of a read.
  - `mem_wen` = 0 only in the ACCESS cycle of a D write.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with both reqs high, then release.
  - During reset: all outputs at their reset values.
  - First edge after release: I granted (`mem_a` = `i_addr`).
- **Lone D write:** D write with `d_addr` = 7'h05, `d_wdata` = 32'hDEADBEEF.
  - Cycle N+1: `mem_cen` = 0, `mem_wen` = 0, `mem_a` = 5, `mem_d` = DEADBEEF.
  - Cycle N+2: `d_ack` = 1, `stall` = 0.
- **Contended read/read:** I read at addr 0x10 and D read at addr 0x20 (model SRAM preloaded to 32'h0000_0010 and 32'h0000_0020), both asserted together.
  - N+2: `i_ack` = 1 with `rdata` = 0x10.
  - N+4: `d_ack` = 1 with `rdata` = 0x20.
  - `stall` = 1 through N+3.
- **Fairness:** both ports hold `req` continuously for 8 cycles.
  - Acks alternate I, D, I, D at cycles N+2, N+4, N+6, N+8.
  - `last` toggles each grant.
- **Write-then-read:** D write 32'h12345678 to 0x7F, then a D read of 0x7F immediately after the ack.
  - The read acks 3 cycles after the write ack, with `rdata` = 32'h12345678.
- **Reset in ACCESS:** assert `rst_n` = 0 while in ACCESS of a D write.
  - Next edge: `mem_cen` = 1, `mem_wen` = 1, state IDLE.
  - No `d_ack` at any point.
